// File: rtl/axil_cmd_queue_if.sv
// AXI4-Lite slave channel bundle for the command queue register block.
interface axil_cmd_queue_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axil_cmd_queue.sv
// AXI4-Lite command queue: CMD/ARG registers feed a FIFO towards the
// accelerator; tracks busy, last command cycle count and a sticky IRQ.
module axil_cmd_queue #(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int          NARG      = 3,
  parameter int          DEPTH     = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  axil_cmd_queue_if.slave      s_axi,
  output logic                 CMD_VALID,
  input  logic                 CMD_READY,
  output logic [31:0]          CMD_DATA,
  output logic [32*NARG-1:0]   CMD_ARGS,
  input  logic                 DONE,
  output logic                 IRQ
);
  localparam int IW = $clog2(NARG + 3);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 32 * (NARG + 1);
  localparam logic [IW-1:0] IDX_STATUS = IW'(NARG + 1);
  localparam logic [IW-1:0] IDX_CYCLES = IW'(NARG + 2);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0]       aw_addr_q, aw_addr_d, w_data_q, w_data_d;
  logic [3:0]        w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       cmd_q, cmd_d, cycles_q, cycles_d, counter_q, counter_d;
  logic [NARG-1:0][31:0] arg_q, arg_d;
  logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              busy_q, busy_d, irq_pending_q, irq_pending_d;
  logic              irq_en_q, irq_en_d, irq_q, irq_d;

  logic              aw_hs, w_hs, ar_hs, commit, push, pop, full, w1c;
  logic [31:0]       wr_addr, wr_data, status_val, rd_val;
  logic [3:0]        wr_strb;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic              rd_ok;

  function automatic logic addr_hit(input logic [31:0] a);
    return ((a >> (IW + 2)) == (ADDR_BASE >> (IW + 2))) && (a[1:0] == 2'b00);
  endfunction

  assign full       = (count_q == CW'(DEPTH));
  assign status_val = {12'b0, irq_en_q, irq_pending_q, busy_q, full, 16'(count_q)};

  // Next-state for the AXI channels, register file, FIFO, busy tracking and IRQ
  always_comb begin
    aw_held_d     = aw_held_q;
    aw_addr_d     = aw_addr_q;
    w_held_d      = w_held_q;
    w_data_d      = w_data_q;
    w_strb_d      = w_strb_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    rvalid_d      = rvalid_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    cmd_d         = cmd_q;
    arg_d         = arg_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    busy_d        = busy_q;
    counter_d     = counter_q;
    cycles_d      = cycles_q;
    irq_pending_d = irq_pending_q;
    irq_en_d      = irq_en_q;
    irq_d         = irq_pending_q & irq_en_q;
    push          = 1'b0;
    w1c           = 1'b0;
    rd_val        = 32'h0;
    rd_ok         = 1'b0;

    // AW and W are captured independently; holding regs stay set until B completes.
    aw_hs = s_axi.S_AXI_AWVALID & ~aw_held_q;
    w_hs  = s_axi.S_AXI_WVALID & ~w_held_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi.S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi.S_AXI_WDATA;
      w_strb_d = s_axi.S_AXI_WSTRB;
    end
    wr_addr = aw_held_q ? aw_addr_q : s_axi.S_AXI_AWADDR;
    wr_data = w_held_q ? w_data_q : s_axi.S_AXI_WDATA;
    wr_strb = w_held_q ? w_strb_q : s_axi.S_AXI_WSTRB;
    wr_idx  = wr_addr[IW+1:2];
    commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;

    if (bvalid_q & s_axi.S_AXI_BREADY) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end

    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = SLVERR;
      if (addr_hit(wr_addr)) begin
        if (wr_idx == '0) begin
          if (wr_strb == 4'b0000) begin
            bresp_d = OKAY;
          end else if (!full) begin
            bresp_d = OKAY;
            push    = 1'b1;
            cmd_d   = wr_data;
          end
        end else if (wr_idx == IDX_STATUS) begin
          bresp_d = OKAY;
          if (wr_strb[2]) begin
            irq_en_d = wr_data[19];
            w1c      = wr_data[18];
          end
        end else begin
          for (int i = 1; i <= NARG; i++) begin
            if (wr_idx == IW'(i)) begin
              bresp_d = OKAY;
              for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) arg_d[i-1][8*b +: 8] = wr_data[8*b +: 8];
              end
            end
          end
        end
      end
    end

    // FIFO: full is judged before any same-cycle pop, so a full push is refused.
    pop = (count_q != '0) & CMD_READY;
    if (push) begin
      mem_d[wr_ptr_q] = {arg_q, wr_data};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Busy/cycle tracking; a DONE coincident with a pop closes out the old command.
    if (busy_q && counter_q != 32'hFFFF_FFFF) counter_d = counter_q + 32'd1;
    if (DONE && busy_q) begin
      busy_d        = 1'b0;
      cycles_d      = (counter_q == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : counter_q + 32'd1;
    end
    if (pop) begin
      busy_d    = 1'b1;
      counter_d = 32'h0;
    end
    if (w1c) irq_pending_d = 1'b0;
    if (DONE && busy_q) irq_pending_d = 1'b1;

    // Read side snapshots register state in the AR handshake cycle.
    rd_idx = s_axi.S_AXI_ARADDR[IW+1:2];
    if (addr_hit(s_axi.S_AXI_ARADDR)) begin
      if (rd_idx == '0) begin
        rd_val = cmd_q;
        rd_ok  = 1'b1;
      end else if (rd_idx == IDX_STATUS) begin
        rd_val = status_val;
        rd_ok  = 1'b1;
      end else if (rd_idx == IDX_CYCLES) begin
        rd_val = cycles_q;
        rd_ok  = 1'b1;
      end else begin
        for (int i = 1; i <= NARG; i++) begin
          if (rd_idx == IW'(i)) begin
            rd_val = arg_q[i-1];
            rd_ok  = 1'b1;
          end
        end
      end
    end
    ar_hs = s_axi.S_AXI_ARVALID & ~rvalid_q;
    if (rvalid_q & s_axi.S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_ok ? OKAY : SLVERR;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held_q     <= 1'b0;
      aw_addr_q     <= '0;
      w_held_q      <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= OKAY;
      rvalid_q      <= 1'b0;
      rresp_q       <= OKAY;
      rdata_q       <= '0;
      cmd_q         <= '0;
      arg_q         <= '0;
      mem_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      busy_q        <= 1'b0;
      counter_q     <= '0;
      cycles_q      <= '0;
      irq_pending_q <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      aw_held_q     <= aw_held_d;
      aw_addr_q     <= aw_addr_d;
      w_held_q      <= w_held_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
      cmd_q         <= cmd_d;
      arg_q         <= arg_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      counter_q     <= counter_d;
      cycles_q      <= cycles_d;
      irq_pending_q <= irq_pending_d;
      irq_en_q      <= irq_en_d;
      irq_q         <= irq_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = ~aw_held_q;
  assign s_axi.S_AXI_WREADY  = ~w_held_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = ~rvalid_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign CMD_VALID = (count_q != '0);
  assign CMD_DATA  = mem_q[rd_ptr_q][31:0];
  assign CMD_ARGS  = mem_q[rd_ptr_q][EW-1:32];
  assign IRQ       = irq_q;
endmodule

// File: tb/tb_axil_cmd_queue.sv
// Self-checking bench for axil_cmd_queue: register vector table plus
// hand-written sequences for FIFO, busy/cycles, IRQ and handshake corners.
module tb_axil_cmd_queue;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam int TIMEOUT = 50;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid, cmd_ready, done, irq;
  logic [31:0] cmd_data;
  logic [95:0] cmd_args;
  int          checks = 0;
  int          errors = 0;

  axil_cmd_queue_if bus();

  axil_cmd_queue #(.ADDR_BASE(32'h0), .NARG(3), .DEPTH(4)) dut (
    .ACLK(aclk), .ARESETN(aresetn), .s_axi(bus),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_DATA(cmd_data),
    .CMD_ARGS(cmd_args), .DONE(done), .IRQ(irq)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timeout got no handshake expected handshake", name);
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_go, w_go, b_done = 0;
    resp = 2'b11;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    for (int i = 0; i < TIMEOUT && !(aw_done && w_done); i++) begin
      aw_go = !aw_done && bus.S_AXI_AWREADY;
      w_go  = !w_done && bus.S_AXI_WREADY;
      tick();
      if (aw_go) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_go)  begin w_done = 1;  bus.S_AXI_WVALID  = 1'b0; end
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) begin
      timeoutFail("write_addr_data");
    end else begin
      for (int i = 0; i < TIMEOUT && !b_done; i++) begin
        if (bus.S_AXI_BVALID) begin
          resp   = bus.S_AXI_BRESP;
          b_done = 1;
        end
        tick();
      end
      if (!b_done) timeoutFail("write_resp");
    end
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit ar_done = 0, r_done = 0;
    resp = 2'b11;
    data = 32'hDEAD_BEEF;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    for (int i = 0; i < TIMEOUT && !ar_done; i++) begin
      if (bus.S_AXI_ARREADY) ar_done = 1;
      tick();
    end
    bus.S_AXI_ARVALID = 1'b0;
    if (!ar_done) begin
      timeoutFail("read_addr");
    end else begin
      for (int i = 0; i < TIMEOUT && !r_done; i++) begin
        if (bus.S_AXI_RVALID) begin
          resp   = bus.S_AXI_RRESP;
          data   = bus.S_AXI_RDATA;
          r_done = 1;
        end
        tick();
      end
      if (!r_done) timeoutFail("read_data");
    end
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic checkRead(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axiRead(addr, d, r);
    checkOutput({name, "_rresp"}, r, exp_resp);
    checkOutput({name, "_rdata"}, d, exp_data);
  endtask

  task automatic checkWrite(input string name, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] r;
    axiWrite(addr, data, strb, r);
    checkOutput({name, "_bresp"}, r, exp_resp);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.is_write) checkWrite(v.name, v.addr, v.data, v.strb, v.exp_resp);
    else            checkRead(v.name, v.addr, v.exp_data, v.exp_resp);
  endtask

  initial begin
    logic [31:0] exp_order[4];
    int bad;

    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 0; bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0;
    bus.S_AXI_WVALID = 0;  bus.S_AXI_BREADY = 0;  bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_RREADY = 0;  cmd_ready = 0; done = 0;

    // Register-access vectors: {write?, addr, data, strb, resp, rdata, name}
    vecs.push_back('{1'b1, 32'h04, 32'h11, 4'hF, OKAY, 32'h0, "w_arg1"});
    vecs.push_back('{1'b1, 32'h08, 32'h22, 4'hF, OKAY, 32'h0, "w_arg2"});
    vecs.push_back('{1'b1, 32'h0C, 32'h33, 4'hF, OKAY, 32'h0, "w_arg3"});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, OKAY, 32'h11, "r_arg1"});
    vecs.push_back('{1'b0, 32'h08, 32'h0, 4'h0, OKAY, 32'h22, "r_arg2"});
    vecs.push_back('{1'b0, 32'h0C, 32'h0, 4'h0, OKAY, 32'h33, "r_arg3"});
    vecs.push_back('{1'b1, 32'h14, 32'h5, 4'hF, SLVERR, 32'h0, "w_cycles_ro"});
    vecs.push_back('{1'b0, 32'h14, 32'h0, 4'h0, OKAY, 32'h0, "r_cycles_reset"});
    vecs.push_back('{1'b0, 32'h18, 32'h0, 4'h0, SLVERR, 32'h0, "r_unmapped"});
    vecs.push_back('{1'b0, 32'h02, 32'h0, 4'h0, SLVERR, 32'h0, "r_misaligned"});
    vecs.push_back('{1'b1, 32'h18, 32'h1, 4'hF, SLVERR, 32'h0, "w_unmapped"});
    vecs.push_back('{1'b1, 32'h20, 32'h1, 4'hF, SLVERR, 32'h0, "w_miss"});
    vecs.push_back('{1'b0, 32'h24, 32'h0, 4'h0, SLVERR, 32'h0, "r_miss_alias"});
    vecs.push_back('{1'b1, 32'h10, 32'h0008_0000, 4'hF, OKAY, 32'h0, "w_status_en"});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, OKAY, 32'h0008_0000, "r_status_en"});
    vecs.push_back('{1'b1, 32'h10, 32'h0, 4'b1011, OKAY, 32'h0, "w_status_nobyte2"});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, OKAY, 32'h0008_0000, "r_status_kept"});
    vecs.push_back('{1'b1, 32'h10, 32'h0, 4'hF, OKAY, 32'h0, "w_status_clr"});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, OKAY, 32'h0, "r_status_clr"});
    vecs.push_back('{1'b1, 32'h00, 32'hDEAD, 4'h0, OKAY, 32'h0, "w_cmd_nostrb"});
    vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, OKAY, 32'h0, "r_status_nopush"});
    vecs.push_back('{1'b1, 32'h04, 32'h0, 4'hF, OKAY, 32'h0, "w_arg1_zero"});
    vecs.push_back('{1'b1, 32'h04, 32'hFFFF, 4'b0010, OKAY, 32'h0, "w_arg1_byte1"});
    vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, OKAY, 32'h0000_FF00, "r_arg1_byte1"});
    vecs.push_back('{1'b1, 32'h04, 32'h11, 4'hF, OKAY, 32'h0, "w_arg1_restore"});

    repeat (3) tick();
    checkOutput("reset_awready", bus.S_AXI_AWREADY, 1'b1);
    checkOutput("reset_wready", bus.S_AXI_WREADY, 1'b1);
    checkOutput("reset_arready", bus.S_AXI_ARREADY, 1'b1);
    checkOutput("reset_bvalid", bus.S_AXI_BVALID, 1'b0);
    checkOutput("reset_rvalid", bus.S_AXI_RVALID, 1'b0);
    checkOutput("reset_cmd_valid", cmd_valid, 1'b0);
    checkOutput("reset_irq", irq, 1'b0);
    aresetn = 1'b1;
    tick();

    foreach (vecs[k]) applyStimulus(vecs[k]);

    // Single push with args captured, then fill to full
    checkWrite("push_a5", 32'h00, 32'hA5, 4'hF, OKAY);
    checkOutput("push_a5_valid", cmd_valid, 1'b1);
    checkOutput("push_a5_data", cmd_data, 32'hA5);
    checkOutput("push_a5_args", cmd_args, 96'h00000033_00000022_00000011);
    checkRead("status_one", 32'h10, 32'h0000_0001, OKAY);
    checkRead("cmd_readback", 32'h00, 32'hA5, OKAY);
    checkWrite("push_2", 32'h00, 32'h2, 4'hF, OKAY);
    checkWrite("push_3", 32'h00, 32'h3, 4'hF, OKAY);
    checkWrite("push_4", 32'h00, 32'h4, 4'hF, OKAY);
    checkWrite("push_full", 32'h00, 32'h5, 4'hF, SLVERR);
    checkRead("status_full", 32'h10, 32'h0001_0004, OKAY);

    exp_order = '{32'hA5, 32'h2, 32'h3, 32'h4};
    foreach (exp_order[k]) begin
      checkOutput("drain_valid", cmd_valid, 1'b1);
      checkOutput("drain_order", cmd_data, exp_order[k]);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
    end
    checkOutput("drained_empty", cmd_valid, 1'b0);
    checkRead("status_busy", 32'h10, 32'h0002_0000, OKAY);
    done = 1'b1; tick(); done = 1'b0;
    checkRead("status_pend_masked", 32'h10, 32'h0004_0000, OKAY);
    checkOutput("irq_masked", irq, 1'b0);
    checkWrite("w1c_masked", 32'h10, 32'h0004_0000, 4'hF, OKAY);
    checkRead("status_after_w1c", 32'h10, 32'h0, OKAY);

    // Cycle count: pop, DONE 10 cycles later
    checkWrite("irq_enable", 32'h10, 32'h0008_0000, 4'hF, OKAY);
    checkWrite("push_77", 32'h00, 32'h77, 4'hF, OKAY);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    repeat (9) tick();
    done = 1'b1; tick(); done = 1'b0;
    checkOutput("irq_registered_delay", irq, 1'b0);
    tick();
    checkOutput("irq_set", irq, 1'b1);
    checkRead("cycles_ten", 32'h14, 32'd10, OKAY);
    checkRead("status_done", 32'h10, 32'h000C_0000, OKAY);
    checkWrite("w1c_pending", 32'h10, 32'h000C_0000, 4'hF, OKAY);
    checkOutput("irq_cleared", irq, 1'b0);
    checkRead("status_w1c", 32'h10, 32'h0008_0000, OKAY);
    done = 1'b1; tick(); done = 1'b0;
    checkRead("cycles_idle_done", 32'h14, 32'd10, OKAY);
    checkRead("status_idle_done", 32'h10, 32'h0008_0000, OKAY);

    // AW three cycles ahead of W, then B held off for five cycles
    bus.S_AXI_AWADDR = 32'h08; bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    checkOutput("aw_held_ready", bus.S_AXI_AWREADY, 1'b0);
    repeat (2) tick();
    checkOutput("no_early_b", bus.S_AXI_BVALID, 1'b0);
    bus.S_AXI_WDATA = 32'h5A5A; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    checkOutput("late_w_bvalid", bus.S_AXI_BVALID, 1'b1);
    checkOutput("late_w_bresp", bus.S_AXI_BRESP, OKAY);
    bus.S_AXI_AWADDR = 32'h0C; bus.S_AXI_AWVALID = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (!(bus.S_AXI_BVALID === 1'b1 && bus.S_AXI_AWREADY === 1'b0 && bus.S_AXI_BRESP === OKAY)) bad++;
    end
    checkOutput("b_stable_aw_stalled", bad, 0);
    bus.S_AXI_BREADY = 1'b1; tick(); bus.S_AXI_BREADY = 1'b0;
    checkOutput("b_done_bvalid", bus.S_AXI_BVALID, 1'b0);
    checkOutput("b_done_awready", bus.S_AXI_AWREADY, 1'b1);
    checkWrite("next_aw", 32'h0C, 32'h0C0C, 4'hF, OKAY);
    checkRead("late_w_arg2", 32'h08, 32'h5A5A, OKAY);
    checkRead("next_aw_arg3", 32'h0C, 32'h0C0C, OKAY);

    // DONE coincident with the pop of the second command
    checkWrite("push_101", 32'h00, 32'h101, 4'hF, OKAY);
    checkWrite("push_102", 32'h00, 32'h102, 4'hF, OKAY);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
    repeat (4) tick();
    done = 1'b1; cmd_ready = 1'b1; tick(); done = 1'b0; cmd_ready = 1'b0;
    checkOutput("coinc_empty", cmd_valid, 1'b0);
    checkRead("coinc_cycles", 32'h14, 32'd5, OKAY);
    checkRead("coinc_status", 32'h10, 32'h000E_0000, OKAY);
    checkOutput("coinc_irq", irq, 1'b1);

    // Reset while commands are queued
    checkWrite("push_201", 32'h00, 32'h201, 4'hF, OKAY);
    checkWrite("push_202", 32'h00, 32'h202, 4'hF, OKAY);
    checkOutput("queued_valid", cmd_valid, 1'b1);
    aresetn = 1'b0;
    repeat (2) tick();
    checkOutput("rst_cmd_valid", cmd_valid, 1'b0);
    checkOutput("rst_irq", irq, 1'b0);
    aresetn = 1'b1;
    tick();
    checkRead("rst_status", 32'h10, 32'h0, OKAY);
    checkRead("rst_cycles", 32'h14, 32'h0, OKAY);
    checkRead("rst_arg1", 32'h04, 32'h0, OKAY);
    checkRead("rst_cmd", 32'h00, 32'h0, OKAY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
